ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//  Front-end stage feeding the robot controller's dist_v input. Periodically fires an
//  ultrasonic trigger pulse, times the returned echo pulse and converts its width into
//  a 16-bit distance. Publishes each result on dist_v with a one-cycle dist_valid strobe.
//  Signals no-echo / over-range as a saturated distance plus a timeout strobe.
// PARAMETERS
//  TRIG_CYCLES      10     trig high time, in clk cycles (>=1)
//  CYCLES_PER_UNIT  58     echo-high clk cycles per distance unit (>=2)
//  TIMEOUT_CYCLES   25000  max cycles in WAIT_ECHO or in MEASURE before abort
//  PERIOD_CYCLES    60000  trigger-to-trigger period; must exceed TRIG+2*TIMEOUT
//  DIST_W           16     width of dist_v
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  echo        in   1       raw sensor echo, asynchronous to clk
//  enable      in   1       1 = run periodic measurements; 0 = finish current, then idle
//  trig        out  1       sensor trigger pulse
//  dist_v      out  DIST_W  last distance (units), held until next result
//  dist_valid  out  1       1-cycle strobe: dist_v updated this cycle
//  timeout     out  1       1-cycle strobe, coincident with dist_valid, on aborted measure
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset values: trig=0, dist_v=0, dist_valid=0, timeout=0, busy=0, state=IDLE, all counters 0.
//  Async assert of rst forces reset immediately; release is sampled on the next clk edge.
//  echo passes through a 2-flop synchroniser (echo_s); echo_s lags echo by 2 clk edges.
//  Period counter pc counts 0..PERIOD_CYCLES-1, wraps, runs only while enable=1 or busy=1.
//  States:
//   IDLE:      when pc==0 and enable=1 and echo_s=0 -> TRIG. If echo_s=1, stay in IDLE
//              (stuck echo) and retry at the next pc==0.
//   TRIG:      trig=1 for exactly TRIG_CYCLES cycles -> WAIT_ECHO (trig registered, no glitch).
//   WAIT_ECHO: echo_s rise -> MEASURE, clearing prescaler and unit count.
//              TIMEOUT_CYCLES elapse without a rise -> result FULL.
//   MEASURE:   prescaler counts 0..CYCLES_PER_UNIT-1. On wrap, unit count +1, saturating
//              at 2^DIST_W-1. On echo_s fall -> result = unit count (partial units truncated).
//              TIMEOUT_CYCLES elapse with echo_s still high -> result FULL.
//   HOLDOFF:   entered after any result; waits for pc wrap to 0, then -> IDLE.
//  Result publication is registered: on the cycle after the deciding edge/event,
//  dist_v<=value and dist_valid=1.
//   - Normal case: echo_s fall seen at edge N -> dist_v/dist_valid valid after edge N+1.
//   - FULL case: dist_v<=all ones, timeout=1 together with dist_valid.
//  A zero-unit echo (shorter than CYCLES_PER_UNIT) publishes dist_v=0, timeout=0.
//  Simultaneous events:
//   - echo_s fall in the same cycle as the timeout threshold: the fall wins (normal result).
//   - Prescaler wrap in the same cycle as the fall: the increment is included.
//  enable deasserted mid-measurement: current measurement completes and publishes,
//  then HOLDOFF -> IDLE, and no new trigger is issued.
//  echo pulses outside WAIT_ECHO/MEASURE are ignored. dist_v never changes without dist_valid.
//  No combinational path from any input to any output.
// TESTING  (TRIG_CYCLES=4, CYCLES_PER_UNIT=5, TIMEOUT_CYCLES=200, PERIOD_CYCLES=500)
//  1 rst high, then release, enable=1, echo=0 -> trig high exactly 4 cycles starting at
//    pc==0; busy=1; dist_v=0 and dist_valid=0 throughout reset.
//  2 echo high for 37 cycles after trig -> exactly one dist_valid pulse, dist_v=7,
//    timeout=0; next trig occurs exactly 500 cycles after the first.
//  3 echo never rises -> 200 cycles after entering WAIT_ECHO, dist_v=16'hFFFF, with
//    dist_valid=1 and timeout=1 for one cycle.
//  4 echo high for 250 cycles -> FULL result after 200 cycles in MEASURE; the later echo
//    fall does not produce a second strobe.
//  5 echo held high before pc==0 -> no trig issued; echo released -> trig at next pc==0.
//  6 enable=0 during MEASURE -> result still published, no further trig. Separately, rst
//    asserted mid-MEASURE -> outputs return to reset values immediately, without a strobe.

Source files
------------

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic range finder: periodic trigger, echo-width timing, distance publication.
// Echo is synchronised before use; all outputs are registered.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES     = 10,
  parameter int CYCLES_PER_UNIT = 58,
  parameter int TIMEOUT_CYCLES  = 25000,
  parameter int PERIOD_CYCLES   = 60000,
  parameter int DIST_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo,
  input  logic              enable,
  output logic              trig,
  output logic [DIST_W-1:0] dist_v,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(PERIOD_CYCLES);
  localparam int SW      = $clog2(CYCLES_PER_UNIT);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

  state_t            state;
  logic              echo_m, echo_s, echo_q;
  logic [PW-1:0]     pc;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     ps;
  logic [DIST_W-1:0] units;
  logic [DIST_W-1:0] units_next;
  logic              ps_wrap;
  logic              pc_wrap;

  // Unit count including a prescaler wrap in the current cycle, saturating.
  always_comb begin
    ps_wrap    = (ps == SW'(CYCLES_PER_UNIT - 1));
    units_next = units;
    if (ps_wrap && (units != '1)) units_next = units + 1'b1;
  end

  assign pc_wrap = (pc == PW'(PERIOD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_q <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_q <= echo_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (enable || busy) pc <= pc_wrap ? '0 : pc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trig       <= 1'b0;
      dist_v     <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      ps         <= '0;
      units      <= '0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if ((pc == '0) && enable && !echo_s) begin
            state <= TRIG;
            trig  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        TRIG: begin
          if (cnt == CW'(TRIG_CYCLES - 1)) begin
            trig  <= 1'b0;
            state <= WAIT_ECHO;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ECHO: begin
          if (echo_s && !echo_q) begin
            state <= MEASURE;
            cnt   <= '0;
            ps    <= '0;
            units <= '0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            dist_v     <= '1;
            dist_valid <= 1'b1;
            timeout    <= 1'b1;
            state      <= HOLDOFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          // Fall is tested first so it beats the timeout threshold in the same cycle.
          if (!echo_s) begin
            dist_v     <= units_next;
            dist_valid <= 1'b1;
            state      <= HOLDOFF;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            dist_v     <= '1;
            dist_valid <= 1'b1;
            timeout    <= 1'b1;
            state      <= HOLDOFF;
          end else begin
            cnt   <= cnt + 1'b1;
            ps    <= ps_wrap ? '0 : ps + 1'b1;
            units <= units_next;
          end
        end
        HOLDOFF: begin
          if (pc_wrap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: echo waveforms are planned per period, expected outputs
// are derived per cycle from pulse timing arithmetic, and compared every cycle.
module tb_ultrasonic_ranger;
  localparam int TRIG = 4;
  localparam int CPU  = 5;
  localparam int TMO  = 200;
  localparam int PER  = 500;
  localparam int DW   = 16;
  localparam int NMAX = 8200;
  localparam int K_PULSE = 0;
  localparam int K_NONE  = 1;
  localparam int K_STUCK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          echo = 1'b0;
  logic          enable = 1'b0;
  logic          trig;
  logic [DW-1:0] dist_v;
  logic          dist_valid;
  logic          timeout;
  logic          busy;

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG),
    .CYCLES_PER_UNIT(CPU),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES(PER),
    .DIST_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .echo(echo),
    .enable(enable),
    .trig(trig),
    .dist_v(dist_v),
    .dist_valid(dist_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n = 0;
  bit prev_trig = 1'b0;

  bit            echo_drv [NMAX];
  bit            exp_trig [NMAX];
  bit            exp_busy [NMAX];
  bit            exp_valid[NMAX];
  bit            exp_to   [NMAX];
  logic [DW-1:0] res_val  [NMAX];
  logic [DW-1:0] exp_dist [NMAX];

  int kind[16];
  int dly[16];
  int wid[16];

  int            trig_q[$];
  int            res_n[$];
  logic [DW-1:0] res_v[$];
  bit            res_to[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, req);
    end
  endtask

  // Expected behaviour: echo seen by the FSM lags the pin by two edges; the result
  // is floor(high cycles / CPU), or FULL when no rise or the pulse outlasts TMO.
  task automatic build_model(input int nper, input int last_trig_p);
    logic [DW-1:0] last;
    int s, e, rise, r, val;
    bit full;
    for (int i = 0; i < NMAX; i++) begin
      echo_drv[i] = 0; exp_trig[i] = 0; exp_busy[i] = 0;
      exp_valid[i] = 0; exp_to[i] = 0; res_val[i] = '0;
    end
    for (int p = 0; p < nper; p++) begin
      s = 1 + PER * p;
      if (kind[p] == K_PULSE) begin
        for (int i = 0; i < wid[p]; i++) echo_drv[s + 4 + dly[p] + i] = 1;
        for (int i = 440; i < 456; i++) echo_drv[s + i] = 1;
      end else if (kind[p] == K_STUCK) begin
        for (int i = -5; i <= 2; i++) echo_drv[s + i] = 1;
      end
    end
    for (int p = 0; p <= last_trig_p; p++) begin
      s = 1 + PER * p;
      if (s >= 3 && echo_drv[s - 2]) continue;
      for (int i = s; i < s + TRIG; i++) exp_trig[i] = 1;
      for (int i = s; i <= s + PER - 2; i++) exp_busy[i] = 1;
      e = s + TRIG; rise = 0; r = 0; val = 0; full = 0;
      for (int t = e + 1; t <= e + TMO; t++)
        if (echo_drv[t - 2] && !echo_drv[t - 3]) begin rise = t; break; end
      if (rise == 0) begin
        r = e + TMO; full = 1;
      end else begin
        for (int j = 1; j <= TMO; j++) begin
          if (!echo_drv[rise + j - 2]) begin r = rise + j; val = j / CPU; break; end
          if (j == TMO) begin r = rise + TMO; full = 1; end
        end
      end
      exp_valid[r] = 1;
      exp_to[r]    = full;
      res_val[r]   = full ? '1 : DW'(val);
    end
    last = '0;
    for (int i = 0; i < NMAX; i++) begin
      if (exp_valid[i]) last = res_val[i];
      exp_dist[i] = last;
    end
  endtask

  task automatic start_session();
    rst = 1'b1; enable = 1'b0; echo = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_trig", trig, 0);
      check("rst_busy", busy, 0);
      check("rst_dist", dist_v, 0);
      check("rst_valid", dist_valid, 0);
      check("rst_timeout", timeout, 0);
    end
    rst = 1'b0; enable = 1'b1; n = 0; prev_trig = 1'b0;
    echo = echo_drv[1];
    trig_q.delete(); res_n.delete(); res_v.delete(); res_to.delete();
  endtask

  task automatic run(input int stop_edge, input int drop_edge);
    while (n < stop_edge) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      check("trig", trig, exp_trig[n]);
      check("busy", busy, exp_busy[n]);
      check("dist_valid", dist_valid, exp_valid[n]);
      check("timeout", timeout, exp_to[n]);
      check("dist_v", dist_v, exp_dist[n]);
      if (trig && !prev_trig) trig_q.push_back(n);
      prev_trig = trig;
      if (dist_valid) begin
        res_n.push_back(n); res_v.push_back(dist_v); res_to.push_back(timeout);
      end
      if (n == drop_edge) enable = 1'b0;
      echo = echo_drv[n + 1];
    end
  endtask

  initial begin
    int drop;
    kind[0] = K_PULSE; dly[0] = $urandom_range(1, 150); wid[0] = 37;
    kind[1] = K_NONE;  dly[1] = 0;                      wid[1] = 0;
    kind[2] = K_PULSE; dly[2] = $urandom_range(1, 150); wid[2] = 250;
    kind[3] = K_STUCK; dly[3] = 0;                      wid[3] = 0;
    kind[4] = K_PULSE; dly[4] = $urandom_range(1, 150); wid[4] = TMO;
    kind[5] = K_PULSE; dly[5] = $urandom_range(1, 150); wid[5] = TMO + 1;
    kind[6] = K_PULSE; dly[6] = $urandom_range(1, 150); wid[6] = CPU - 1;
    kind[7] = K_PULSE; dly[7] = $urandom_range(1, 150); wid[7] = CPU;
    for (int p = 8; p < 14; p++) begin
      kind[p] = ($urandom_range(0, 3) == 0) ? K_NONE : K_PULSE;
      dly[p]  = $urandom_range(1, 150);
      wid[p]  = $urandom_range(1, 260);
    end
    kind[14] = K_PULSE; dly[14] = $urandom_range(1, 150); wid[14] = 120;

    build_model(15, 14);
    start_session();
    drop = 1 + PER * 14 + TRIG + 2 + dly[14] + 10;
    run(1 + PER * 15 + 100, drop);

    check("trig_count", trig_q.size(), 14);
    if (trig_q.size() >= 4) begin
      check("trig0_edge", trig_q[0], 1);
      check("trig1_edge", trig_q[1], 501);
      check("trig_after_stuck", trig_q[3], 2001);
    end
    check("result_count", res_n.size(), 14);
    if (res_n.size() >= 7) begin
      check("r0_dist", res_v[0], 7);
      check("r0_timeout", res_to[0], 0);
      check("r1_edge", res_n[1], 705);
      check("r1_dist", res_v[1], 16'hFFFF);
      check("r1_timeout", res_to[1], 1);
      check("r2_dist", res_v[2], 16'hFFFF);
      check("fall_at_threshold", res_v[3], 40);
      check("over_threshold", res_v[4], 16'hFFFF);
      check("zero_unit", res_v[5], 0);
      check("zero_unit_to", res_to[5], 0);
      check("one_unit", res_v[6], 1);
    end

    kind[0] = K_PULSE; dly[0] = 20; wid[0] = 60;
    kind[1] = K_PULSE; dly[1] = 30; wid[1] = 150;
    build_model(2, 1);
    start_session();
    run(501 + TRIG + 2 + 30 + 40, -1);
    check("b_dist_before", dist_v, 12);
    check("b_busy_before", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("b_rst_busy", busy, 0);
    check("b_rst_dist", dist_v, 0);
    check("b_rst_valid", dist_valid, 0);
    check("b_rst_timeout", timeout, 0);
    check("b_rst_trig", trig, 0);
    enable = 1'b0;
    echo = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("b_post_valid", dist_valid, 0);
      check("b_post_trig", trig, 0);
      check("b_post_dist", dist_v, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
